// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared FSM states and sizing constants for the serial arithmetic blocks
package serial_arith_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int SERIAL_WIDTH_DEF = 8;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_8_if.sv
// rtl/serial_subtractor_8_if.sv - operand/result handshake bundle; op exists only with SERIAL_SUB_ADD_MODE_EN
interface serial_subtractor_8_if #(
  parameter int WIDTH = serial_arith_pkg::SERIAL_WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic             op;

  modport slave  (input  in_valid, x, y, op, out_ready,
                  output in_ready, out_valid, diff, borrow, ovf);
  modport master (output in_valid, x, y, op, out_ready,
                  input  in_ready, out_valid, diff, borrow, ovf);
`else
  modport slave  (input  in_valid, x, y, out_ready,
                  output in_ready, out_valid, diff, borrow, ovf);
  modport master (output in_valid, x, y, out_ready,
                  input  in_ready, out_valid, diff, borrow, ovf);
`endif
endinterface

// File: rtl/serial_bit_cell.sv
// rtl/serial_bit_cell.sv - one-bit full subtractor, or full adder when add is high
module serial_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic add,
  output logic s,
  output logic cout
);

  logic prop;

  assign prop = a ^ b;
  assign s    = prop ^ cin;
  // cin is a borrow-in in subtract mode and a carry-in in add mode
  assign cout = add ? ((a & b) | (prop & cin))
                    : ((~a & b) | (~prop & cin));

endmodule

// File: rtl/serial_subtractor_8.sv
// rtl/serial_subtractor_8.sv - bit-serial LSB-first x-y (x+y with SERIAL_SUB_ADD_MODE_EN and op=1)
module serial_subtractor_8
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_8_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] x_sr;
  logic [WIDTH-1:0] y_sr;
  logic [CNT_W-1:0] cnt;
  logic             b_reg;
  logic             x_msb;
  logic             y_msb;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             add_q;
  logic             d_bit;
  logic             b_out;
  logic             last_bit;
  logic             ovf_next;

`ifndef SERIAL_SUB_ADD_MODE_EN
  assign add_q = 1'b0;
`endif

  serial_bit_cell u_cell (
    .a    (x_sr[0]),
    .b    (y_sr[0]),
    .cin  (b_reg),
    .add  (add_q),
    .s    (d_bit),
    .cout (b_out)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // Same-sign rule for add, different-sign rule for subtract, folded into one compare
  assign ovf_next = (x_msb == (y_msb ^ ~add_q)) && (d_bit != x_msb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (last_bit)      state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // x_sr doubles as the result register: result bits enter at the MSB as operand bits leave the LSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sr     <= '0;
      y_sr     <= '0;
      cnt      <= '0;
      b_reg    <= 1'b0;
      x_msb    <= 1'b0;
      y_msb    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      add_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_sr  <= bus.x;
            y_sr  <= bus.y;
            cnt   <= '0;
            b_reg <= 1'b0;
            x_msb <= bus.x[WIDTH-1];
            y_msb <= bus.y[WIDTH-1];
`ifdef SERIAL_SUB_ADD_MODE_EN
            add_q <= bus.op;
`endif
          end
        end
        RUN: begin
          x_sr  <= {d_bit, x_sr[WIDTH-1:1]};
          y_sr  <= {1'b0, y_sr[WIDTH-1:1]};
          b_reg <= b_out;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            diff_q   <= {d_bit, x_sr[WIDTH-1:1]};
            borrow_q <= b_out;
            ovf_q    <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_8.sv
// tb/tb_serial_subtractor_8.sv - directed-vector bench for serial_subtractor_8
module tb_serial_subtractor_8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor_8_if #(.WIDTH(8)) bus ();

  serial_subtractor_8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called 1 time unit after a posedge while the block is in IDLE; returns 1 unit after E0
  task automatic capture(input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.x        = a;
    bus.y        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.x        = ~a;
    bus.y        = ~b;
  endtask

  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 20);
    check({tag, "_lat"}, lat, 8);
  endtask

  task automatic check_result(input string tag, input logic [7:0] ed, input logic eb, input logic eo);
    check({tag, "_diff"},   bus.diff,     ed);
    check({tag, "_borrow"}, bus.borrow,   eb);
    check({tag, "_ovf"},    bus.ovf,      eo);
    check({tag, "_inrdy"},  bus.in_ready, 1'b0);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_ovalid_off"}, bus.out_valid, 1'b0);
    check({tag, "_inrdy_on"},   bus.in_ready,  1'b1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input logic eo);
    capture(a, b);
    wait_result(tag);
    check_result(tag, ed, eb, eo);
    release_result(tag);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
    bus.op        = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_inrdy",  bus.in_ready,  1'b1);
    check("rst_ovalid", bus.out_valid, 1'b0);
    check("rst_diff",   bus.diff,      8'h00);
    check("rst_borrow", bus.borrow,    1'b0);
    check("rst_ovf",    bus.ovf,       1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("v00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("v01_00", 8'h01, 8'h00, 8'h01, 1'b0, 1'b0);
    run_op("v01_01", 8'h01, 8'h01, 8'h00, 1'b0, 1'b0);
    run_op("v00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op("v80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("v7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Abort an operation in its 4th RUN cycle; outputs must clear without a clock edge
    capture(8'h55, 8'h0F);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_inrdy",  bus.in_ready,  1'b1);
    check("arst_ovalid", bus.out_valid, 1'b0);
    check("arst_diff",   bus.diff,      8'h00);
    check("arst_borrow", bus.borrow,    1'b0);
    check("arst_ovf",    bus.ovf,       1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("v05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

    // Backpressure: result held while a new operand pair waits at the input
    capture(8'h10, 8'h03);
    wait_result("bp");
    bus.in_valid = 1'b1;
    bus.x        = 8'h20;
    bus.y        = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_ovalid", bus.out_valid, 1'b1);
      check("bp_inrdy",  bus.in_ready,  1'b0);
      check("bp_diff",   bus.diff,      8'h0D);
      check("bp_borrow", bus.borrow,    1'b0);
    end
    release_result("bp");
    capture(8'h20, 8'h01);
    wait_result("bp2");
    check_result("bp2", 8'h1F, 1'b0, 1'b0);
    release_result("bp2");

`ifdef SERIAL_SUB_ADD_MODE_EN
    bus.op = 1'b1;
    run_op("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    bus.op = 1'b0;
    run_op("sub_after_add", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
